// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg: instruction field positions, sequencer states, idle word.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int INST_ACC      = 49;
  localparam int INST_CEN_PMEM = 48;
  localparam int INST_WEN_PMEM = 47;
  localparam int A_PMEM_MSB    = 46;
  localparam int A_PMEM_LSB    = 33;
  localparam int INST_CEN1     = 32;
  localparam int A1_MSB        = 31;
  localparam int A1_LSB        = 21;
  localparam int INST_CEN0     = 20;
  localparam int INST_WEN0     = 19;
  localparam int A0_MSB        = 18;
  localparam int A0_LSB        = 8;
  localparam int INST_OFIFO_RD = 7;
  localparam int INST_IFIFO_WR = 6;
  localparam int INST_IFIFO_RD = 5;
  localparam int INST_L0_RD    = 4;
  localparam int INST_L0_WR    = 3;
  localparam int INST_MODE     = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  // PE rows of the array; the row word width lives in the datapath.
  localparam int PE_ROWS = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WLOAD      = 3'd1,
    S_ACT        = 3'd2,
    S_FLUSH      = 3'd3,
    S_WAIT_DRAIN = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [49:0] IDLE_INST = (50'd1 << INST_CEN_PMEM) | (50'd1 << INST_WEN_PMEM) |
                                      (50'd1 << INST_CEN1)     | (50'd1 << INST_CEN0)     |
                                      (50'd1 << INST_WEN0);

endpackage
`default_nettype wire

// File: rtl/psum_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_drain: writes each valid OFIFO row to consecutive pmem slots.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module psum_drain #(
  parameter int AW = 11,
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [CW-1:0] i_total,
  input  logic          i_ofifo_valid,
  output logic          o_cen_pmem,
  output logic          o_wen_pmem,
  output logic [AW-1:0] o_a_pmem,
  output logic          o_ofifo_rd,
  output logic          o_drain_done
);

  logic [AW-1:0] r_base;
  logic [CW-1:0] r_total;
  logic [CW-1:0] r_count;
  logic          r_cen;
  logic          r_wen;
  logic [AW-1:0] r_addr;
  logic          r_rd;
  logic          w_wr;
  logic [AW-1:0] w_addr;

  // Surplus rows beyond the run total are left in the OFIFO.
  assign w_wr         = ~i_start && i_ofifo_valid && (r_count < r_total);
  assign w_addr       = r_base + r_count[AW-1:0];
  assign o_drain_done = (r_count == r_total);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_total <= '0;
      r_count <= '0;
      r_cen   <= 1'b1;
      r_wen   <= 1'b1;
      r_addr  <= '0;
      r_rd    <= 1'b0;
    end else begin
      if (i_start) begin
        r_base  <= i_base;
        r_total <= i_total;
        r_count <= '0;
      end else if (w_wr) begin
        r_count <= r_count + CW'(1);
      end
      r_cen  <= ~w_wr;
      r_wen  <= ~w_wr;
      r_addr <= w_wr ? w_addr : '0;
      r_rd   <= w_wr;
    end
  end

  assign o_cen_pmem = r_cen;
  assign o_wen_pmem = r_wen;
  assign o_a_pmem   = r_addr;
  assign o_ofifo_rd = r_rd;

endmodule
`default_nettype wire

// File: rtl/core_inst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_inst_seq: per-kij weight load / activation / flush sequencer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module core_inst_seq
  import core_pkg::*;
#(
  parameter int          COL     = 8,
  parameter int          LEN_NIJ = 1024,
  parameter int          LEN_KIJ = 9,
  parameter logic [10:0] W_BASE  = 11'h400,
  parameter int          PMEM_AW = 11,
  parameter int          INST_W  = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(LEN_KIJ+1)-1:0] num_kij,
  input  logic [PMEM_AW-1:0]           pmem_base,
  input  logic                         l0_ready,
  input  logic                         ofifo_valid,
  output logic                         busy,
  output logic                         done,
  output logic [INST_W-1:0]            inst
);

  localparam int KW    = $clog2(LEN_KIJ + 1);
  localparam int T_MAX = (COL > LEN_NIJ) ? COL : LEN_NIJ;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int TOT_W = $clog2(LEN_KIJ * LEN_NIJ + 1);
  localparam int CW    = (TOT_W > PMEM_AW) ? TOT_W : PMEM_AW;

  state_t             r_state, w_next;
  logic [KW-1:0]      r_kij, r_num_kij, w_kij_nx, w_nk_eff;
  logic [TW-1:0]      r_t;
  logic               w_start_acc, w_rd, w_t_inc, w_t_clr, w_kij_inc;
  logic [2:0]         w_ctl, r_ctl1, r_ctl2, r_ctl3;
  logic [10:0]        w_a0, w_a0_w, w_a0_x, r_a0;
  logic               r_cen0, r_l0_wr, r_l0_rd, r_busy, r_done;
  logic [CW-1:0]      w_total;
  logic               w_cen_pmem, w_wen_pmem, w_ofifo_rd, w_drain_done, w_pipe_empty;
  logic [PMEM_AW-1:0] w_a_pmem;
  logic [13:0]        w_a_pmem_ext;

  assign w_nk_eff = (num_kij == '0) ? KW'(1) : num_kij;
  assign w_total  = CW'(w_nk_eff) * CW'(LEN_NIJ);
  assign w_kij_nx = r_kij + KW'(1);
  assign w_a0_w   = W_BASE + 11'(r_kij) * 11'(COL) + 11'(r_t);
  assign w_a0_x   = 11'(r_t);
  assign w_pipe_empty = r_cen0 && (r_ctl1 == 3'b0) && (r_ctl2 == 3'b0) && (r_ctl3 == 3'b0)
                        && ~r_l0_wr && ~r_l0_rd;

  psum_drain #(.AW(PMEM_AW), .CW(CW)) u_drain (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_start_acc),
    .i_base       (pmem_base),
    .i_total      (w_total),
    .i_ofifo_valid(ofifo_valid),
    .o_cen_pmem   (w_cen_pmem),
    .o_wen_pmem   (w_wen_pmem),
    .o_a_pmem     (w_a_pmem),
    .o_ofifo_rd   (w_ofifo_rd),
    .o_drain_done (w_drain_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // w_ctl is {mode, execute, load}
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_rd        = 1'b0;
    w_ctl       = 3'b000;
    w_a0        = '0;
    w_t_inc     = 1'b0;
    w_t_clr     = 1'b0;
    w_kij_inc   = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_start_acc = 1'b1;
        w_next      = S_WLOAD;
      end
      S_WLOAD: if (l0_ready) begin
        w_rd  = 1'b1;
        w_ctl = 3'b001;
        w_a0  = w_a0_w;
        if (r_t == TW'(COL - 1)) begin
          w_t_clr = 1'b1;
          w_next  = S_ACT;
        end else begin
          w_t_inc = 1'b1;
        end
      end
      S_ACT: if (l0_ready) begin
        w_rd  = 1'b1;
        w_ctl = 3'b010;
        w_a0  = w_a0_x;
        if (r_t == TW'(LEN_NIJ - 1)) begin
          w_t_clr = 1'b1;
          w_next  = S_FLUSH;
        end else begin
          w_t_inc = 1'b1;
        end
      end
      S_FLUSH: begin
        w_ctl     = 3'b111;
        w_kij_inc = 1'b1;
        w_next    = (w_kij_nx < r_num_kij) ? S_WLOAD : S_WAIT_DRAIN;
      end
      S_WAIT_DRAIN: if (w_drain_done && w_pipe_empty) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kij     <= '0;
      r_num_kij <= '0;
      r_t       <= '0;
    end else if (w_start_acc) begin
      r_kij     <= '0;
      r_num_kij <= w_nk_eff;
      r_t       <= '0;
    end else begin
      if (w_t_clr)      r_t <= '0;
      else if (w_t_inc) r_t <= r_t + TW'(1);
      if (w_kij_inc)    r_kij <= w_kij_nx;
    end
  end

  // WEN0 is always high (reads only), so an L0 write follows every low CEN0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cen0  <= 1'b1;
      r_a0    <= '0;
      r_ctl1  <= '0;
      r_ctl2  <= '0;
      r_ctl3  <= '0;
      r_l0_wr <= 1'b0;
      r_l0_rd <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cen0  <= ~w_rd;
      r_a0    <= w_a0;
      r_ctl1  <= w_ctl;
      r_ctl2  <= r_ctl1;
      r_ctl3  <= r_ctl2;
      r_l0_wr <= ~r_cen0;
      r_l0_rd <= r_l0_wr;
      r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_comb begin
    w_a_pmem_ext                = '0;
    w_a_pmem_ext[PMEM_AW-1:0]   = w_a_pmem;
  end

  always_comb begin
    inst                        = '0;
    inst[INST_CEN_PMEM]         = w_cen_pmem;
    inst[INST_WEN_PMEM]         = w_wen_pmem;
    inst[A_PMEM_MSB:A_PMEM_LSB] = w_a_pmem_ext;
    inst[INST_CEN1]             = 1'b1;
    inst[INST_CEN0]             = r_cen0;
    inst[INST_WEN0]             = 1'b1;
    inst[A0_MSB:A0_LSB]         = r_a0;
    inst[INST_OFIFO_RD]         = w_ofifo_rd;
    inst[INST_L0_RD]            = r_l0_rd;
    inst[INST_L0_WR]            = r_l0_wr;
    inst[INST_MODE]             = r_ctl3[2];
    inst[INST_EXECUTE]          = r_ctl3[1];
    inst[INST_LOAD]             = r_ctl3[0];
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_core_inst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_inst_seq: queue-based reference model compared every cycle.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_core_inst_seq;

  localparam int COL     = 8;
  localparam int LEN_NIJ = 16;
  localparam int LEN_KIJ = 9;
  localparam int PMEM_AW = 11;
  localparam int INST_W  = 50;
  localparam int KW      = $clog2(LEN_KIJ + 1);
  localparam logic [49:0] IDLE_LIT = 50'h1800100180000;

  logic               clk = 1'b0;
  logic               reset, start, l0_ready, ofifo_valid;
  logic [KW-1:0]      num_kij;
  logic [PMEM_AW-1:0] pmem_base;
  logic               busy, done;
  logic [INST_W-1:0]  inst;

  core_inst_seq #(
    .COL(COL), .LEN_NIJ(LEN_NIJ), .LEN_KIJ(LEN_KIJ), .W_BASE(11'h400),
    .PMEM_AW(PMEM_AW), .INST_W(INST_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_kij(num_kij), .pmem_base(pmem_base),
    .l0_ready(l0_ready), .ofifo_valid(ofifo_valid), .busy(busy), .done(done), .inst(inst)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending operations for the whole run.
  // kind 0 = weight read (load), 1 = activation read (execute), 2 = flush.
  typedef struct packed {logic rd; logic [10:0] a0; logic ld; logic ex; logic md;} dec_t;
  dec_t d0, d1, d2;
  int   q_kind[$];
  int   q_addr[$];
  int   ph, nk, total, cnt, base, flush_n, edge_n, cyc;
  logic e_wr, e_busy, e_done;
  int   e_ap;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   obs_a0[$], obs_rc[$], obs_ld[$], obs_ap[$];
  int   obs_done, obs_flush;

  task automatic model_reset();
    d0 = '0; d1 = '0; d2 = '0;
    q_kind.delete(); q_addr.delete();
    ph = 0; cnt = 0; total = 0; base = 0;
    e_wr = 1'b0; e_ap = 0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_edge();
    dec_t d;
    logic wr;
    int   ap;
    edge_n++;
    d  = '0;
    wr = ((ph == 1) || (ph == 2)) && ofifo_valid && (cnt < total);
    ap = (base + cnt) % (1 << PMEM_AW);
    case (ph)
      0: if (start) begin
        nk    = (num_kij == 0) ? 1 : int'(num_kij);
        base  = int'(pmem_base);
        total = nk * LEN_NIJ;
        cnt   = 0;
        for (int k = 0; k < nk; k++) begin
          for (int t = 0; t < COL; t++) begin
            q_kind.push_back(0); q_addr.push_back((1024 + k * COL + t) % 2048);
          end
          for (int t = 0; t < LEN_NIJ; t++) begin
            q_kind.push_back(1); q_addr.push_back(t % 2048);
          end
          q_kind.push_back(2); q_addr.push_back(0);
        end
        ph = 1;
      end
      1: begin
        if (q_kind[0] == 2) begin
          d.ld = 1'b1; d.ex = 1'b1; d.md = 1'b1;
          void'(q_kind.pop_front()); void'(q_addr.pop_front());
          if (q_kind.size() == 0) begin
            ph = 2;
            flush_n = edge_n;
          end
        end else if (l0_ready) begin
          d.rd = 1'b1;
          d.a0 = 11'(q_addr[0]);
          d.ld = (q_kind[0] == 0);
          d.ex = (q_kind[0] == 1);
          void'(q_kind.pop_front()); void'(q_addr.pop_front());
        end
      end
      // the flush word leaves inst three edges after its decision
      2: if ((edge_n >= flush_n + 4) && (cnt == total)) ph = 3;
      default: ph = 0;
    endcase
    if (wr) cnt++;
    d2 = d1; d1 = d0; d0 = d;
    e_wr   = wr;
    e_ap   = wr ? ap : 0;
    e_busy = (ph == 1) || (ph == 2);
    e_done = (ph == 3);
  endtask

  function automatic logic [49:0] exp_inst();
    logic [49:0] e;
    e        = '0;
    e[48]    = ~e_wr;
    e[47]    = ~e_wr;
    e[46:33] = 14'(e_ap);
    e[32]    = 1'b1;
    e[20]    = ~d0.rd;
    e[19]    = 1'b1;
    e[18:8]  = d0.a0;
    e[7]     = e_wr;
    e[4]     = d2.rd;
    e[3]     = d1.rd;
    e[2]     = d2.md;
    e[1]     = d2.ex;
    e[0]     = d2.ld;
    return e;
  endfunction

  task automatic compare();
    logic [49:0] e;
    e = exp_inst();
    n_cmp++;
    if (inst !== e) begin
      n_bad++;
      $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst, e);
    end
    n_cmp++;
    if (busy !== e_busy) begin
      n_bad++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
    end
    n_cmp++;
    if (done !== e_done) begin
      n_bad++;
      $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, e_done);
    end
    if (!inst[20]) begin obs_a0.push_back(int'(inst[18:8])); obs_rc.push_back(cyc); end
    if (inst[0] && !inst[2]) obs_ld.push_back(cyc);
    if (!inst[47]) obs_ap.push_back(int'(inst[46:33]));
    if (done) obs_done++;
    if (inst[2]) obs_flush++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
    cyc++;
    compare();
    #1;
  endtask

  task automatic clear_obs();
    obs_a0.delete(); obs_rc.delete(); obs_ld.delete(); obs_ap.delete();
    obs_done = 0; obs_flush = 0;
  endtask

  task automatic run(input int nkv, input int pb, input bit l0r, input bit ovr,
                     input bit stall5, input bit restart, input bit abort7);
    int n;
    int st;
    clear_obs();
    num_kij     = KW'(nkv);
    pmem_base   = PMEM_AW'(pb);
    start       = 1'b1;
    l0_ready    = 1'b1;
    ofifo_valid = 1'b1;
    tick();
    start = 1'b0;
    n  = 0;
    st = 0;
    while (n < 3000) begin
      if (ph == 0) break;
      if (abort7 && ph == 1 && q_kind.size() > 0 && q_kind[0] == 1 && q_addr[0] == 7) break;
      l0_ready = l0r ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall5 && ph == 1 && q_kind.size() > 0 && q_kind[0] == 1 && q_addr[0] == 5 && st < 3) begin
        l0_ready = 1'b0;
        st++;
      end
      ofifo_valid = ovr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (restart && n == 10) begin
        start   = 1'b1;
        num_kij = KW'(3);
      end
      tick();
      start = 1'b0;
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout got=%0d exp=<3000 cycles", n);
    end
    l0_ready    = 1'b1;
    ofifo_valid = 1'b0;
  endtask

  initial begin
    cyc = 0; edge_n = 0; flush_n = 0; nk = 0;
    reset = 1'b1; start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b0;
    num_kij = KW'(1); pmem_base = '0;
    model_reset();
    clear_obs();
    repeat (2) tick();
    chk("reset_inst", 64'(inst), 64'(IDLE_LIT));
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // basic single pass
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_reads", obs_a0.size(), 24);
    chk("t1_a0_first", qat(obs_a0, 0), 'h400);
    chk("t1_a0_w7", qat(obs_a0, 7), 'h407);
    chk("t1_a0_act0", qat(obs_a0, 8), 0);
    chk("t1_a0_act15", qat(obs_a0, 23), 15);
    chk("t1_writes", obs_ap.size(), 16);
    chk("t1_ap_last", qat(obs_ap, 15), 15);
    chk("t1_flush", obs_flush, 1);
    chk("t1_done", obs_done, 1);

    // two passes, load latency
    run(2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_a0_k1_first", qat(obs_a0, 24), 'h408);
    chk("t2_a0_k1_last", qat(obs_a0, 31), 'h40F);
    chk("t2_writes", obs_ap.size(), 32);
    chk("t2_lag_k0", qat(obs_ld, 0) - qat(obs_rc, 0), 2);
    chk("t2_lag_k1", qat(obs_ld, 8) - qat(obs_rc, 24), 2);

    // three-cycle stall at activation 5
    run(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_reads", obs_a0.size(), 24);
    chk("t3_a0_resume", qat(obs_a0, COL + 5), 5);
    chk("t3_gap", qat(obs_rc, COL + 5) - qat(obs_rc, COL + 4), 4);

    // pmem address wrap
    run(1, 2046, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_ap0", qat(obs_ap, 0), 2046);
    chk("t4_ap1", qat(obs_ap, 1), 2047);
    chk("t4_ap2", qat(obs_ap, 2), 0);
    chk("t4_ap3", qat(obs_ap, 3), 1);

    // abort by reset during activation streaming
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    model_reset();
    tick();
    chk("t5_inst_idle", 64'(inst), 64'(IDLE_LIT));
    chk("t5_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_no_done", obs_done, 0);
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_rerun_a0", qat(obs_a0, 0), 'h400);
    chk("t5_rerun_done", obs_done, 1);

    // num_kij=0 runs once; restart while busy ignored
    run(0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_reads", obs_a0.size(), 24);
    chk("t6_writes", obs_ap.size(), 16);
    chk("t6_ap_first", qat(obs_ap, 0), 5);
    chk("t6_done", obs_done, 1);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      run($urandom_range(1, 3), $urandom_range(0, 2047), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Hardware instruction sequencer that generates the packed core instruction word, replacing the hand-written stimulus loop.
- For each kernel index (kij) it does three things: streams `col` weight words from xmem into L0 and loads the array, then streams `len_nij` activation words in execute mode, then issues a one-cycle mode-switch/flush.
- A concurrent drain engine writes every valid OFIFO row to pmem.
- Run-time kij count and pmem base address; start/busy/done handshake toward the host.

Parameters:
- col, 8, PE columns = weight words per kij
- row, 8, PE rows (documentation only; the word width lives in the datapath)
- len_nij, 1024, activation words per kij
- len_kij, 9, maximum kij count
- w_base, 11'h400, xmem address of kij 0 weights; kij k starts at w_base + k*col
- pmem_aw, 11, pmem address width (≤14, zero-extended into the inst field)
- inst_w, 50, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle run request; sampled only in IDLE
- num_kij  in  $clog2(len_kij+1)  number of kij passes, 1..len_kij; 0 is treated as 1; latched at start
- pmem_base  in  pmem_aw  first pmem write address; latched at start
- l0_ready  in  1  L0 can accept a word this cycle
- ofifo_valid  in  1  OFIFO holds a readable row
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- inst  out  inst_w  instruction bus, bit fields below

Instruction field layout:
- [49] acc
- [48] CEN_pmem
- [47] WEN_pmem
- [46:33] A_pmem
- [32] CEN1_xmem
- [31:21] A1_xmem
- [20] CEN0_xmem
- [19] WEN0_xmem
- [18:8] A0_xmem
- [7] ofifo_rd
- [6] ififo_wr
- [5] ififo_rd
- [4] l0_rd
- [3] l0_wr
- [2] mode
- [1] execute
- [0] load

Behaviour:
- Reset values: all outputs registered; busy=0, done=0.
  - inst: CEN0/WEN0/CEN1/CEN_pmem/WEN_pmem = 1; every other bit 0.
  - acc, ififo_wr, ififo_rd and A1 stay constant 0, CEN1 stays 1, in every state.
- FSM states: IDLE, WLOAD, ACT, FLUSH, WAIT_DRAIN, DONE.
  - IDLE: start=1 latches num_kij and pmem_base, clears kij/t counters and sets busy=1; WLOAD is entered the next cycle.
  - WLOAD: each cycle with l0_ready=1 issues an xmem read (CEN0=0, WEN0=1, A0=w_base+kij*col+t) and load=1, then t++. A cycle with l0_ready=0 issues CEN0=1 and holds t. After col issued reads: t=0, go to ACT.
  - ACT: same stall rule; A0=t, execute=1, load=0. After len_nij reads go to FLUSH.
  - FLUSH: one cycle with load=execute=mode=1 and CEN0=1. Then kij++. If kij<num_kij go to WLOAD, else WAIT_DRAIN.
  - WAIT_DRAIN: idle instruction (load=execute=mode=0) until the drain count reaches num_kij*len_nij and the control pipeline is empty; then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - Memory fields (CEN0, WEN0, A0) appear on inst 1 cycle after the FSM decision.
  - load/execute/mode pass through 2 extra stages and appear 3 cycles after the decision, aligning with the xmem read plus L0 write.
  - l0_wr = (CEN0_xmem==0 && WEN0_xmem==1), registered one cycle after those fields drive inst.
  - l0_rd = l0_wr delayed one cycle.
- Drain engine (concurrent, active while busy):
  - Each cycle with ofifo_valid=1 and count < num_kij*len_nij it issues CEN_pmem=0, WEN_pmem=0 and ofifo_rd=1, all in the same inst word.
  - A_pmem = pmem_base + count, so the first write goes to pmem_base; count++ after each write.
  - Surplus ofifo_valid is ignored once the count is reached.
- Boundary conditions:
  - start while busy is ignored.
  - A_pmem wraps modulo 2^pmem_aw; A0 wraps modulo 2^11.
  - l0_ready low for N cycles stalls exactly N cycles; no read is skipped or duplicated.
  - reset mid-run aborts immediately: outputs return to reset values, the pipeline is cleared, and done is not pulsed.
- Arithmetic: counters are sized $clog2(max+1); kij*col is computed at 11 bits.

Decomposition:
- Shared package core_pkg holds:
  - inst bit-position constants (INST_ACC … INST_LOAD, A0/A1/A_pmem LSB and MSB);
  - the FSM state enum;
  - the idle-instruction constant.
- One sub-module, psum_drain: the pmem write counter/address/ofifo_rd logic with inputs start, base, total, ofifo_valid, and outputs the pmem fields and drain_done.

Test Plan:
1. col=8, len_nij=16, num_kij=1, l0_ready=1, ofifo_valid on 16 cycles → 8 reads A0=0x400..0x407 with load; 16 reads A0=0..15 with execute; one flush with mode=1; 16 pmem writes A_pmem=0..15; done pulses once.
2. num_kij=2 → second WLOAD reads A0=0x408..0x40F; 32 pmem writes in total; the delay from each kij's first read to the first load=1 on inst is 2 cycles.
3. l0_ready deasserted for 3 cycles mid-ACT at t=5 → CEN0=1 for those 3 cycles, reads resume at A0=5, no gaps or duplicates.
4. pmem_base=2046, pmem_aw=11, 4 writes → A_pmem=2046, 2047, 0, 1.
5. reset pulsed during ACT → next cycle inst equals the idle constant, busy=0, no done pulse; a subsequent start runs cleanly from A0=0x400.
6. start re-pulsed while busy, and num_kij=0 → the second start has no effect; num_kij=0 runs exactly one pass.
